// File: rtl/multi_cycle_control.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the 3-bit ALU operation.
module multi_cycle_control #(
    parameter int OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                zero,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [2:0]          alu_op
);

    localparam logic [OP_WIDTH-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_WIDTH-1:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_UNS = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    ctrl_t  fetch_ctrl;

    // ALU operation for register/immediate arithmetic; only R-type (opcode[5]=1) can subtract.
    function automatic logic [2:0] funct_alu_op(input logic       op5,
                                                input logic [2:0] f3,
                                                input logic       f7_5);
        logic [2:0] op;
        case (f3)
            3'b000:  op = (op5 & f7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_UNS;
        endcase
        return op;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] fop);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                // Branch target old_pc + imm lands in alu_out for BEQ to use.
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = fop;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = fop;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALU_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                // rd gets old_pc + 4 in ALUWB; alu_out still holds the jump target.
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [OP_WIDTH-1:0] op);
        state_t n;
        case (s)
            S_FETCH: n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_R:         n = S_EXEC_R;
                    OP_I:         n = S_EXEC_I;
                    OP_BEQ:       n = S_BEQ;
                    OP_JAL:       n = S_JAL;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR:   n = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = S_MEMWB;
            S_EXEC_R:   n = S_ALUWB;
            S_EXEC_I:   n = S_ALUWB;
            S_JAL:      n = S_ALUWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d = next_state(state_q, opcode);
    end

    // Outputs are precomputed for the state being entered so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, funct_alu_op(opcode[5], funct3, funct7_5));
        end
    end

    assign fetch_ctrl = state_ctrl(S_FETCH, ALU_ADD);

    // Reset must silence every write immediately, even before the state register has settled.
    assign pc_write   = ~rst & (ctrl_q.pc_update | (ctrl_q.branch & zero));
    assign mem_write  = ~rst & ctrl_q.mem_write;
    assign ir_write   = ~rst & ctrl_q.ir_write;
    assign reg_write  = ~rst & ctrl_q.reg_write;
    assign adr_src    = rst ? fetch_ctrl.adr_src    : ctrl_q.adr_src;
    assign result_src = rst ? fetch_ctrl.result_src : ctrl_q.result_src;
    assign alu_src_a  = rst ? fetch_ctrl.alu_src_a  : ctrl_q.alu_src_a;
    assign alu_src_b  = rst ? fetch_ctrl.alu_src_b  : ctrl_q.alu_src_b;
    assign alu_op     = rst ? fetch_ctrl.alu_op     : ctrl_q.alu_op;

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Table-driven bench for multi_cycle_control: per-cycle vectors feed a scoreboard queue that is
// drained and compared on the falling clock edge.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_op;

    multi_cycle_control #(.OP_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b}
    localparam logic [10:0] B_RST   = 11'b0_0_0_0_0_10_00_10;
    localparam logic [10:0] B_FETCH = 11'b1_0_0_1_0_10_00_10;
    localparam logic [10:0] B_DEC   = 11'b0_0_0_0_0_00_01_01;
    localparam logic [10:0] B_MADR  = 11'b0_0_0_0_0_00_10_01;
    localparam logic [10:0] B_MRD   = 11'b0_1_0_0_0_00_00_00;
    localparam logic [10:0] B_MWB   = 11'b0_0_0_0_1_01_00_00;
    localparam logic [10:0] B_MWR   = 11'b0_1_1_0_0_00_00_00;
    localparam logic [10:0] B_EXR   = 11'b0_0_0_0_0_00_10_00;
    localparam logic [10:0] B_EXI   = 11'b0_0_0_0_0_00_10_01;
    localparam logic [10:0] B_AWB   = 11'b0_0_0_0_1_00_00_00;
    localparam logic [10:0] B_BEQ0  = 11'b0_0_0_0_0_00_10_00;
    localparam logic [10:0] B_BEQ1  = 11'b1_0_0_0_0_00_10_00;
    localparam logic [10:0] B_JAL   = 11'b1_0_0_0_0_00_01_10;
    localparam logic [15:0] ALL = 16'hFFFF;
    localparam logic [15:0] MD  = 16'hF9FF;  // result_src is free in DECODE

    typedef struct {
        logic        r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [15:0] exp;
        logic [15:0] mask;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;

    wire [15:0] got = {pc_write, adr_src, mem_write, ir_write, reg_write,
                       result_src, alu_src_a, alu_src_b, imm_src, alu_op};

    function automatic logic [15:0] E(input logic [10:0] b, input logic [1:0] imm,
                                      input logic [2:0] op);
        return {b, imm, op};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [15:0] ex, input logic [15:0] m,
                       input string n);
        vec_t v;
        v.r = r; v.opc = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = ex; v.mask = m; v.name = n;
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        rst = v.r; opcode = v.opc; funct3 = v.f3; funct7_5 = v.f7; zero = v.z;
        e.exp = v.exp; e.mask = v.mask; e.name = v.name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                failures++;
                $display("FAIL %s: got=%04h expected=%04h (mask %04h) at %0t",
                         e.name, got, e.exp, e.mask, $time);
            end
        end
    end

    initial begin
        // Reset held two cycles, then R-type sub and I-type with funct7_5=1 (still add).
        add(1, RT, 3'b000, 1, 0, E(B_RST,   2'b00, 3'b000), ALL, "rst_c0");
        add(1, RT, 3'b000, 1, 0, E(B_RST,   2'b00, 3'b000), ALL, "rst_c1");
        add(0, RT, 3'b000, 1, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "r_fetch");
        add(0, RT, 3'b000, 1, 0, E(B_DEC,   2'b00, 3'b000), MD,  "r_decode");
        add(0, RT, 3'b000, 1, 0, E(B_EXR,   2'b00, 3'b001), ALL, "r_exec_sub");
        add(0, RT, 3'b000, 1, 0, E(B_AWB,   2'b00, 3'b000), ALL, "r_aluwb");
        add(0, IT, 3'b000, 1, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "i_fetch");
        add(0, IT, 3'b000, 1, 0, E(B_DEC,   2'b00, 3'b000), MD,  "i_decode");
        add(0, IT, 3'b000, 1, 0, E(B_EXI,   2'b00, 3'b000), ALL, "i_exec_add");
        add(0, IT, 3'b000, 1, 0, E(B_AWB,   2'b00, 3'b000), ALL, "i_aluwb");
        // lw: five cycles, write-back only in the last
        add(0, LW, 3'b010, 0, 1, E(B_FETCH, 2'b00, 3'b000), ALL, "lw_fetch");
        add(0, LW, 3'b010, 0, 1, E(B_DEC,   2'b00, 3'b000), MD,  "lw_decode");
        add(0, LW, 3'b010, 0, 1, E(B_MADR,  2'b00, 3'b000), ALL, "lw_memadr");
        add(0, LW, 3'b010, 0, 1, E(B_MRD,   2'b00, 3'b000), ALL, "lw_memread");
        add(0, LW, 3'b010, 0, 1, E(B_MWB,   2'b00, 3'b000), ALL, "lw_memwb");
        // sw: four cycles
        add(0, SW, 3'b010, 0, 0, E(B_FETCH, 2'b01, 3'b000), ALL, "sw_fetch");
        add(0, SW, 3'b010, 0, 0, E(B_DEC,   2'b01, 3'b000), MD,  "sw_decode");
        add(0, SW, 3'b010, 0, 0, E(B_MADR,  2'b01, 3'b000), ALL, "sw_memadr");
        add(0, SW, 3'b010, 0, 0, E(B_MWR,   2'b01, 3'b000), ALL, "sw_memwrite");
        // beq taken, then not taken; zero held high outside BEQ must not move PC
        add(0, BQ, 3'b000, 0, 1, E(B_FETCH, 2'b10, 3'b000), ALL, "beq1_fetch");
        add(0, BQ, 3'b000, 0, 1, E(B_DEC,   2'b10, 3'b000), MD,  "beq1_decode");
        add(0, BQ, 3'b000, 0, 1, E(B_BEQ1,  2'b10, 3'b001), ALL, "beq1_taken");
        add(0, BQ, 3'b000, 0, 0, E(B_FETCH, 2'b10, 3'b000), ALL, "beq0_fetch");
        add(0, BQ, 3'b000, 0, 0, E(B_DEC,   2'b10, 3'b000), MD,  "beq0_decode");
        add(0, BQ, 3'b000, 0, 0, E(B_BEQ0,  2'b10, 3'b001), ALL, "beq0_nottaken");
        // jal, then an unknown opcode that returns straight to FETCH
        add(0, JL, 3'b000, 0, 0, E(B_FETCH, 2'b11, 3'b000), ALL, "jal_fetch");
        add(0, JL, 3'b000, 0, 0, E(B_DEC,   2'b11, 3'b000), MD,  "jal_decode");
        add(0, JL, 3'b000, 0, 0, E(B_JAL,   2'b11, 3'b000), ALL, "jal_jal");
        add(0, JL, 3'b000, 0, 1, E(B_AWB,   2'b11, 3'b000), ALL, "jal_aluwb");
        add(0, BAD, 3'b000, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "bad_fetch");
        add(0, BAD, 3'b000, 0, 1, E(B_DEC,   2'b00, 3'b000), MD,  "bad_decode");
        // funct decode variants
        add(0, RT, 3'b010, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "slt_fetch");
        add(0, RT, 3'b010, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "slt_decode");
        add(0, RT, 3'b010, 0, 0, E(B_EXR,   2'b00, 3'b101), ALL, "slt_exec");
        add(0, RT, 3'b010, 0, 0, E(B_AWB,   2'b00, 3'b000), ALL, "slt_aluwb");
        add(0, IT, 3'b110, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "ori_fetch");
        add(0, IT, 3'b110, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "ori_decode");
        add(0, IT, 3'b110, 0, 0, E(B_EXI,   2'b00, 3'b010), ALL, "ori_exec");
        add(0, IT, 3'b110, 0, 0, E(B_AWB,   2'b00, 3'b000), ALL, "ori_aluwb");
        add(0, RT, 3'b111, 1, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "and_fetch");
        add(0, RT, 3'b111, 1, 0, E(B_DEC,   2'b00, 3'b000), MD,  "and_decode");
        add(0, RT, 3'b111, 1, 0, E(B_EXR,   2'b00, 3'b011), ALL, "and_exec");
        add(0, RT, 3'b111, 1, 0, E(B_AWB,   2'b00, 3'b000), ALL, "and_aluwb");
        add(0, IT, 3'b001, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "uns_fetch");
        add(0, IT, 3'b001, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "uns_decode");
        add(0, IT, 3'b001, 0, 0, E(B_EXI,   2'b00, 3'b111), ALL, "uns_exec");
        add(0, IT, 3'b001, 0, 0, E(B_AWB,   2'b00, 3'b000), ALL, "uns_aluwb");
        add(0, RT, 3'b000, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "add_fetch");
        add(0, RT, 3'b000, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "add_decode");
        add(0, RT, 3'b000, 0, 0, E(B_EXR,   2'b00, 3'b000), ALL, "add_exec");
        add(0, RT, 3'b000, 0, 0, E(B_AWB,   2'b00, 3'b000), ALL, "add_aluwb");
        // reset during MEMADR of sw: no store, next cycle is FETCH
        add(0, SW, 3'b010, 0, 0, E(B_FETCH, 2'b01, 3'b000), ALL, "swr_fetch");
        add(0, SW, 3'b010, 0, 0, E(B_DEC,   2'b01, 3'b000), MD,  "swr_decode");
        add(1, SW, 3'b010, 0, 0, E(B_RST,   2'b01, 3'b000), ALL, "swr_rst_memadr");
        add(0, SW, 3'b010, 0, 0, E(B_FETCH, 2'b01, 3'b000), ALL, "swr_refetch");
        add(0, SW, 3'b010, 0, 0, E(B_DEC,   2'b01, 3'b000), MD,  "swr_decode2");
        add(0, SW, 3'b010, 0, 0, E(B_MADR,  2'b01, 3'b000), ALL, "swr_memadr2");
        add(0, SW, 3'b010, 0, 0, E(B_MWR,   2'b01, 3'b000), ALL, "swr_memwrite2");

        foreach (tbl[i]) step(tbl[i]);

        // lw aborted by reset in MEMREAD, then restarted
        begin
            vec_t v;
            v = '{0, LW, 3'b010, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "lwr_fetch"};   step(v);
            v = '{0, LW, 3'b010, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "lwr_decode"};  step(v);
            v = '{0, LW, 3'b010, 0, 0, E(B_MADR,  2'b00, 3'b000), ALL, "lwr_memadr"};  step(v);
            v = '{1, LW, 3'b010, 0, 1, E(B_RST,   2'b00, 3'b000), ALL, "lwr_rst"};     step(v);
            v = '{0, LW, 3'b010, 0, 0, E(B_FETCH, 2'b00, 3'b000), ALL, "lwr_refetch"}; step(v);
            v = '{0, LW, 3'b010, 0, 0, E(B_DEC,   2'b00, 3'b000), MD,  "lwr_decode2"}; step(v);
        end
        // finish that lw, then beqs with random zero: only BEQ cycle may follow it
        begin
            vec_t v;
            v = '{0, LW, 3'b010, 0, 1, E(B_MADR, 2'b00, 3'b000), ALL, "lwr_memadr2"}; step(v);
            v = '{0, LW, 3'b010, 0, 1, E(B_MRD,  2'b00, 3'b000), ALL, "lwr_memread"}; step(v);
            v = '{0, LW, 3'b010, 0, 1, E(B_MWB,  2'b00, 3'b000), ALL, "lwr_memwb"};   step(v);
            for (int k = 0; k < 6; k++) begin
                logic zr;
                logic zd;
                logic zb;
                zr = 1'($urandom_range(0, 1));
                zd = 1'($urandom_range(0, 1));
                zb = 1'($urandom_range(0, 1));
                v = '{0, BQ, 3'b000, 0, zr, E(B_FETCH, 2'b10, 3'b000), ALL, "rbeq_fetch"};
                step(v);
                v = '{0, BQ, 3'b000, 0, zd, E(B_DEC, 2'b10, 3'b000), MD, "rbeq_decode"};
                step(v);
                v = '{0, BQ, 3'b000, 0, zb, E(zb ? B_BEQ1 : B_BEQ0, 2'b10, 3'b001), ALL,
                      "rbeq_beq"};
                step(v);
            end
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
